// File: rtl/cpu_controller_if.sv
// rtl/cpu_controller_if.sv - control/status bundle between cpu_controller and its datapath.
interface cpu_controller_if;
  logic [2:0] opcode;
  logic       zero;
  logic       memReady;
  logic       pcClear;
  logic       pcInc;
  logic       pcLoad;
  logic       irLoad;
  logic       acLoad;
  logic       memRd;
  logic       memWr;
  logic       addrSel;
  logic       halted;
  logic       busErr;

  modport master (
    input  opcode, zero, memReady,
    output pcClear, pcInc, pcLoad, irLoad, acLoad, memRd, memWr, addrSel, halted, busErr
  );

  modport slave (
    output opcode, zero, memReady,
    input  pcClear, pcInc, pcLoad, irLoad, acLoad, memRd, memWr, addrSel, halted, busErr
  );
endinterface

// File: rtl/cpu_controller.sv
// rtl/cpu_controller.sv - fetch/decode/execute sequencer for an 8-bit accumulator CPU.
// Optional memory wait timeout enabled by defining CPU_CTRL_TIMEOUT_EN.
module cpu_controller #(
  parameter int unsigned TIMEOUT_CYCLES = 15
) (
  input logic              clk,
  input logic              resetN,
  cpu_controller_if.master bus
);

  typedef enum logic [2:0] {
    S_RST,
    S_FETCH,
    S_DECODE,
    S_EXEC_RD,
    S_EXEC_WR,
    S_HALT
  } state_t;

  localparam logic [2:0] OP_HLT = 3'b000;
  localparam logic [2:0] OP_SKZ = 3'b001;
  localparam logic [2:0] OP_STO = 3'b110;
  localparam logic [2:0] OP_JMP = 3'b111;

  state_t state;

`ifdef CPU_CTRL_TIMEOUT_EN
  localparam logic [3:0] WAIT_LAST = 4'(TIMEOUT_CYCLES - 1);

  logic [3:0] wait_cnt;
  logic       bus_err;

  // The counter is zero whenever a wait state is entered; it only advances while stalled.
  always_ff @(posedge clk or negedge resetN) begin
    if (!resetN) begin
      state    <= S_RST;
      wait_cnt <= 4'd0;
      bus_err  <= 1'b0;
    end else begin
      wait_cnt <= 4'd0;
      case (state)
        S_RST: state <= S_FETCH;
        S_FETCH, S_EXEC_RD, S_EXEC_WR: begin
          if (bus.memReady) begin
            state <= (state == S_FETCH) ? S_DECODE : S_FETCH;
          end else if (wait_cnt == WAIT_LAST) begin
            state   <= S_HALT;
            bus_err <= 1'b1;
          end else begin
            wait_cnt <= wait_cnt + 4'd1;
          end
        end
        S_DECODE: begin
          case (bus.opcode)
            OP_HLT:         state <= S_HALT;
            OP_SKZ, OP_JMP: state <= S_FETCH;
            OP_STO:         state <= S_EXEC_WR;
            default:        state <= S_EXEC_RD;
          endcase
        end
        default: state <= S_HALT;
      endcase
    end
  end

  assign bus.busErr = resetN & bus_err;
`else
  always_ff @(posedge clk or negedge resetN) begin
    if (!resetN) begin
      state <= S_RST;
    end else begin
      case (state)
        S_RST: state <= S_FETCH;
        S_FETCH, S_EXEC_RD, S_EXEC_WR: begin
          if (bus.memReady) begin
            state <= (state == S_FETCH) ? S_DECODE : S_FETCH;
          end
        end
        S_DECODE: begin
          case (bus.opcode)
            OP_HLT:         state <= S_HALT;
            OP_SKZ, OP_JMP: state <= S_FETCH;
            OP_STO:         state <= S_EXEC_WR;
            default:        state <= S_EXEC_RD;
          endcase
        end
        default: state <= S_HALT;
      endcase
    end
  end

  // Without the wait counter there is no bus error source; the limit has no effect.
  assign bus.busErr = 1'b0 & (TIMEOUT_CYCLES != 0);
`endif

  // Outputs are gated by resetN so that everything reads 0 while reset is held,
  // even though the state register already sits in RST.
  always_comb begin
    bus.pcClear = 1'b0;
    bus.pcInc   = 1'b0;
    bus.pcLoad  = 1'b0;
    bus.irLoad  = 1'b0;
    bus.acLoad  = 1'b0;
    bus.memRd   = 1'b0;
    bus.memWr   = 1'b0;
    bus.addrSel = 1'b0;
    bus.halted  = 1'b0;
    if (resetN) begin
      case (state)
        S_RST: bus.pcClear = 1'b1;
        S_FETCH: begin
          bus.memRd  = 1'b1;
          bus.irLoad = bus.memReady;
          bus.pcInc  = bus.memReady;
        end
        S_DECODE: begin
          if (bus.opcode == OP_SKZ) begin
            bus.pcInc = bus.zero;
          end else if (bus.opcode == OP_JMP) begin
            bus.pcLoad  = 1'b1;
            bus.addrSel = 1'b1;
          end
        end
        S_EXEC_RD: begin
          bus.memRd   = 1'b1;
          bus.addrSel = 1'b1;
          bus.acLoad  = bus.memReady;
        end
        S_EXEC_WR: begin
          bus.memWr   = 1'b1;
          bus.addrSel = 1'b1;
        end
        default: bus.halted = 1'b1;
      endcase
    end
  end

endmodule

// File: tb/tb_cpu_controller.sv
// tb/tb_cpu_controller.sv - directed self-checking bench for cpu_controller.
module tb_cpu_controller;

  logic clk;
  logic resetN;
  int   total;
  int   bad;

  cpu_controller_if bus ();

  cpu_controller #(.TIMEOUT_CYCLES(15)) dut (
    .clk    (clk),
    .resetN (resetN),
    .bus    (bus.master)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // {pcClear,pcInc,pcLoad,irLoad,acLoad,memRd,memWr,addrSel,halted,busErr}
  logic [9:0] outs;
  assign outs = {bus.pcClear, bus.pcInc, bus.pcLoad, bus.irLoad, bus.acLoad,
                 bus.memRd, bus.memWr, bus.addrSel, bus.halted, bus.busErr};

  localparam logic [9:0] O_NONE    = 10'b0000000000;
  localparam logic [9:0] O_CLEAR   = 10'b1000000000;
  localparam logic [9:0] O_FETCHOK = 10'b0101010000;
  localparam logic [9:0] O_FWAIT   = 10'b0000010000;
  localparam logic [9:0] O_JMP     = 10'b0010000100;
  localparam logic [9:0] O_SKIP    = 10'b0100000000;
  localparam logic [9:0] O_RDWAIT  = 10'b0000010100;
  localparam logic [9:0] O_RDDONE  = 10'b0000110100;
  localparam logic [9:0] O_WR      = 10'b0000001100;
  localparam logic [9:0] O_HALT    = 10'b0000000010;
  localparam logic [9:0] O_BUSERR  = 10'b0000000011;

  task automatic chk(input string tag, input logic [9:0] expv);
    #1;
    total++;
    assert (outs === expv) else begin
      bad++;
      $error("FAIL %s observed=%b expected=%b", tag, outs, expv);
    end
  endtask

  task automatic cycle();
    @(posedge clk);
    #1;
  endtask

  task automatic release_reset();
    @(negedge clk);
    resetN = 1'b1;
  endtask

  initial begin
    total        = 0;
    bad          = 0;
    resetN       = 1'b0;
    bus.opcode   = 3'b000;
    bus.zero     = 1'b0;
    bus.memReady = 1'b0;

    #3;
    chk("reset_hold", O_NONE);
    bus.memReady = 1'b1;
    chk("reset_hold_ready", O_NONE);
    cycle();
    cycle();

    release_reset();
    chk("rst_pcclear", O_CLEAR);
    cycle();
    chk("fetch_zero_wait", O_FETCHOK);

    bus.opcode = 3'b111;
    cycle();
    chk("jmp_decode", O_JMP);
    bus.memReady = 1'b0;
    cycle();
    chk("jmp_fetch_no_inc", O_FWAIT);
    bus.memReady = 1'b1;
    chk("jmp_fetch_done", O_FETCHOK);

    bus.opcode = 3'b001;
    bus.zero   = 1'b1;
    cycle();
    chk("skz_zero1", O_SKIP);
    cycle();
    chk("skz_fetch", O_FETCHOK);
    bus.zero = 1'b0;
    cycle();
    chk("skz_zero0", O_NONE);
    cycle();
    chk("skz0_fetch", O_FETCHOK);

    bus.opcode = 3'b010;
    cycle();
    chk("add_decode", O_NONE);
    bus.memReady = 1'b0;
    cycle();
    chk("add_wait1", O_RDWAIT);
    cycle();
    chk("add_wait2", O_RDWAIT);
    cycle();
    chk("add_wait3", O_RDWAIT);
    bus.memReady = 1'b1;
    chk("add_done", O_RDDONE);
    cycle();
    chk("add_back_fetch", O_FETCHOK);

    bus.opcode = 3'b110;
    bus.memReady = 1'b0;
    cycle();
    chk("sto_wait_fetch", O_FWAIT);
    bus.memReady = 1'b1;
    cycle();
    chk("sto_decode_ready_ignored", O_NONE);
    bus.memReady = 1'b0;
    chk("sto_decode_notready", O_NONE);
    bus.memReady = 1'b1;
    cycle();
    chk("sto_exec_wr", O_WR);
    cycle();
    chk("sto_back_fetch", O_FETCHOK);

    bus.opcode = 3'b000;
    cycle();
    chk("hlt_decode", O_NONE);
    for (int i = 0; i < 6; i++) begin
      bus.memReady = i[0];
      cycle();
      chk("halt_hold", O_HALT);
    end

    resetN = 1'b0;
    chk("halt_async_reset", O_NONE);
    cycle();
    release_reset();
    chk("halt_reset_pcclear", O_CLEAR);
    bus.memReady = 1'b0;
    cycle();
    chk("stall_fetch_entry", O_FWAIT);

`ifdef CPU_CTRL_TIMEOUT_EN
    for (int i = 1; i < 15; i++) begin
      cycle();
      chk("stall_fetch_wait", O_FWAIT);
    end
    cycle();
    chk("timeout_halt", O_BUSERR);
    bus.memReady = 1'b1;
    cycle();
    chk("timeout_sticky", O_BUSERR);
    resetN = 1'b0;
    chk("timeout_reset_clears", O_NONE);
    release_reset();
    chk("timeout_reset_pcclear", O_CLEAR);
`else
    for (int i = 1; i < 20; i++) begin
      cycle();
      chk("stall_no_timeout", O_FWAIT);
    end
    bus.memReady = 1'b1;
    chk("stall_released", O_FETCHOK);
    cycle();
    chk("stall_decode", O_NONE);
`endif

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
